// File: rtl/counter_capture_pkg.sv
// Shared widths and the capture entry layout for the counter capture FIFO.
package counter_capture_pkg;
    localparam int CNT_W_DEF  = 4;
    localparam int EXT_W_DEF  = 12;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    typedef struct packed {
        logic [EXT_W_DEF-1:0] ext;
        logic [CNT_W_DEF-1:0] cnt;
    } cap_entry_t;
endpackage

// File: rtl/cap_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module cap_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             wr_en;
    logic             rd_en;

    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Flags are registered from the next occupancy so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/counter_capture_fifo.sv
// Extends an upstream 4-bit counter with a wrap counter and queues timestamp
// snapshots taken on capture_req; also flags upstream overflow edges.
module counter_capture_fifo
    import counter_capture_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EXT_W  = EXT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   ovf_in,
    input  logic                   capture_req,
    output logic                   cap_valid,
    input  logic                   cap_ready,
    output logic [EXT_W+CNT_W-1:0] cap_data,
    output logic                   fifo_full,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   ovf_seen,
    output logic                   ovf_rise
);
    logic [CNT_W-1:0] cnt_q;
    logic             prim;
    logic [EXT_W-1:0] ext_cnt;
    logic [EXT_W-1:0] ext_nxt;
    logic             wrap;
    logic             pop;
    logic             fifo_empty;

    // A wrap is only the all-ones -> zero step; other jumps (upstream reset) are ignored.
    assign wrap    = prim && (cnt_q == '1) && (cnt_in == '0);
    assign ext_nxt = ext_cnt + {{(EXT_W-1){1'b0}}, wrap};

    // Handshake: the head on cap_data transfers on any edge where cap_valid && cap_ready;
    // cap_data holds steady while cap_valid is high and cap_ready is low.
    assign pop       = cap_valid && cap_ready;
    assign cap_valid = !fifo_empty;

    cap_sync_fifo #(
        .WIDTH (EXT_W + CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture_req),
        .push_data ({ext_nxt, cnt_in}),
        .pop       (pop),
        .pop_data  (cap_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            prim       <= 1'b0;
            ext_cnt    <= '0;
            drop_count <= '0;
            ovf_seen   <= 1'b0;
            ovf_rise   <= 1'b0;
        end else begin
            cnt_q    <= cnt_in;
            prim     <= 1'b1;
            ext_cnt  <= ext_nxt;
            ovf_seen <= ovf_in;
            ovf_rise <= ovf_in && !ovf_seen;
            if (capture_req && fifo_full && !pop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_counter_capture_fifo.sv
// Directed bench for counter_capture_fifo: captures are scoreboarded through
// an expected queue and popped entries are checked in order.
module tb_counter_capture_fifo;
    import counter_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cnt_in;
    logic        ovf_in;
    logic        capture_req;
    logic        cap_valid;
    logic        cap_ready;
    logic [15:0] cap_data;
    logic        fifo_full;
    logic [7:0]  drop_count;
    logic        ovf_seen;
    logic        ovf_rise;

    logic [15:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    counter_capture_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_in      (cnt_in),
        .ovf_in      (ovf_in),
        .capture_req (capture_req),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .cap_data    (cap_data),
        .fifo_full   (fifo_full),
        .drop_count  (drop_count),
        .ovf_seen    (ovf_seen),
        .ovf_rise    (ovf_rise)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] entry(input logic [11:0] e, input logic [3:0] c);
        cap_entry_t t;
        t.ext = e;
        t.cnt = c;
        return t;
    endfunction

    // One clock: drive inputs, check/pop the head if it transfers, queue the capture if accepted.
    task automatic drive(input logic [3:0] c, input logic cap, input logic rdy,
                         input logic [15:0] exp_val, input logic exp_acc);
        logic [15:0] head;
        cnt_in      = c;
        capture_req = cap;
        cap_ready   = rdy;
        if (cap_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {16'h0, cap_data}, 32'hffff_ffff);
            end else begin
                head = exp_q.pop_front();
                chk("pop_data", {16'h0, cap_data}, {16'h0, head});
            end
        end
        if (cap && exp_acc) exp_q.push_back(exp_val);
        tick();
    endtask

    task automatic idle(input logic [3:0] c, input logic rdy);
        drive(c, 1'b0, rdy, 16'h0, 1'b0);
    endtask

    initial begin
        logic [3:0] rc;
        int         drop_exp;

        reset = 1'b1; cnt_in = '0; ovf_in = 1'b0; capture_req = 1'b0; cap_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'h0, cap_valid}, 32'h0);
        chk("rst_data", {16'h0, cap_data}, 32'h0);
        chk("rst_full", {31'h0, fifo_full}, 32'h0);
        chk("rst_drop", {24'h0, drop_count}, 32'h0);
        chk("rst_ovf_seen", {31'h0, ovf_seen}, 32'h0);
        chk("rst_ovf_rise", {31'h0, ovf_rise}, 32'h0);
        reset = 1'b0;

        // Count 0..15 then 0: capture on the wrap cycle, then at 3.
        for (int i = 0; i < 16; i++) idle(4'(i), 1'b1);
        drive(4'h0, 1'b1, 1'b1, 16'h0010, 1'b1);
        idle(4'h1, 1'b1);
        idle(4'h2, 1'b1);
        chk("no_bypass", {31'h0, cap_valid}, 32'h0);
        drive(4'h3, 1'b1, 1'b1, 16'h0013, 1'b1);
        chk("lat_valid", {31'h0, cap_valid}, 32'h1);
        chk("lat_data", {16'h0, cap_data}, 32'h0013);
        idle(4'h7, 1'b1);
        // 7 -> 0 is an upstream jump, not a wrap.
        drive(4'h0, 1'b1, 1'b1, 16'h0010, 1'b1);
        idle(4'h4, 1'b1);
        idle(4'h4, 1'b1);
        chk("drain1_valid", {31'h0, cap_valid}, 32'h0);
        chk("drain1_q", exp_q.size(), 32'h0);

        // Six captures with no consumer: four stored, two dropped.
        for (int i = 4; i < 10; i++) drive(4'(i), 1'b1, 1'b0, entry(12'h1, 4'(i)), i < 8);
        drop_exp = 2;
        chk("full_flag", {31'h0, fifo_full}, 32'h1);
        chk("full_drop", {24'h0, drop_count}, drop_exp);
        idle(4'h9, 1'b1);
        chk("full_clear", {31'h0, fifo_full}, 32'h0);
        for (int i = 0; i < 3; i++) idle(4'h9, 1'b1);
        chk("drain2_valid", {31'h0, cap_valid}, 32'h0);
        chk("drain2_q", exp_q.size(), 32'h0);

        // Fill, then push and pop together for three cycles (last one also wraps).
        for (int i = 10; i < 14; i++) drive(4'(i), 1'b1, 1'b0, entry(12'h1, 4'(i)), 1'b1);
        chk("fill_full", {31'h0, fifo_full}, 32'h1);
        drive(4'he, 1'b1, 1'b1, 16'h001e, 1'b1);
        drive(4'hf, 1'b1, 1'b1, 16'h001f, 1'b1);
        drive(4'h0, 1'b1, 1'b1, 16'h0020, 1'b1);
        chk("pp_full", {31'h0, fifo_full}, 32'h1);
        chk("pp_drop", {24'h0, drop_count}, drop_exp);
        for (int i = 0; i < 4; i++) idle(4'h0, 1'b1);
        chk("drain3_valid", {31'h0, cap_valid}, 32'h0);
        chk("drain3_q", exp_q.size(), 32'h0);

        // 300 captures against a stalled consumer: drop counter saturates.
        for (int i = 0; i < 300; i++) begin
            rc = 4'($urandom_range(1, 14));
            drive(rc, 1'b1, 1'b0, entry(12'h2, rc), i < 4);
        end
        chk("sat_drop", {24'h0, drop_count}, 32'd255);
        idle(4'h1, 1'b1);
        idle(4'h1, 1'b1);
        chk("pre_rst_valid", {31'h0, cap_valid}, 32'h1);

        // Reset with two entries still queued.
        reset = 1'b1; capture_req = 1'b0; cap_ready = 1'b0;
        tick();
        chk("midrst_valid", {31'h0, cap_valid}, 32'h0);
        chk("midrst_drop", {24'h0, drop_count}, 32'h0);
        chk("midrst_full", {31'h0, fifo_full}, 32'h0);
        exp_q.delete();
        reset = 1'b0;

        // 4095 wraps to reach ext=0xFFF, then one more rolls to 0.
        idle(4'hf, 1'b1);
        for (int i = 0; i < 4095; i++) begin
            idle(4'h0, 1'b1);
            idle(4'hf, 1'b1);
        end
        drive(4'h5, 1'b1, 1'b1, 16'hfff5, 1'b1);
        idle(4'hf, 1'b1);
        drive(4'h0, 1'b1, 1'b1, 16'h0000, 1'b1);
        drive(4'h2, 1'b1, 1'b1, 16'h0002, 1'b1);
        for (int i = 0; i < 3; i++) idle(4'h2, 1'b1);
        chk("roll_q", exp_q.size(), 32'h0);

        // Overflow edge: rise driven at cycle 20 after reset.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 1; i < 20; i++) idle(4'h3, 1'b0);
        chk("ovf_pre_seen", {31'h0, ovf_seen}, 32'h0);
        chk("ovf_pre_rise", {31'h0, ovf_rise}, 32'h0);
        ovf_in = 1'b1;
        idle(4'h3, 1'b0);
        chk("ovf_seen", {31'h0, ovf_seen}, 32'h1);
        chk("ovf_rise", {31'h0, ovf_rise}, 32'h1);
        idle(4'h3, 1'b0);
        chk("ovf_seen_hold", {31'h0, ovf_seen}, 32'h1);
        chk("ovf_rise_pulse", {31'h0, ovf_rise}, 32'h0);
        ovf_in = 1'b0;
        idle(4'h3, 1'b0);
        chk("ovf_seen_clr", {31'h0, ovf_seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_capture_fifo.md
Name: counter_capture_fifo

Overview:
- Sits directly downstream of the 4-bit enable/overflow up-counter.
- Extends the counter's range by counting its wrap-arounds in a wide extension register.
- On a capture strobe, snapshots the extended timestamp {ext_cnt, cnt_in} into a small FIFO.
- Software/logic drains the FIFO through a valid/ready handshake.

Parameters:
- CNT_W, 4: width of the upstream counter value.
- EXT_W, 12: width of the wrap (extension) counter.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- DROP_W, 8: width of the saturating dropped-capture counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_in  input  CNT_W  upstream counter value.
- ovf_in  input  1  upstream overflow flag; sticky until upstream reset.
- capture_req  input  1  one-cycle capture strobe; treated as a level each cycle.
- cap_valid  output  1  FIFO non-empty; head entry present on cap_data.
- cap_ready  input  1  consumer accepts head when cap_valid && cap_ready.
- cap_data  output  EXT_W+CNT_W  head entry, {ext, cnt}.
- fifo_full  output  1  FIFO holds DEPTH entries.
- drop_count  output  DROP_W  captures lost because FIFO was full; saturates.
- ovf_seen  output  1  ovf_in registered by one cycle.
- ovf_rise  output  1  one-cycle pulse on 0->1 of ovf_in.

Behaviour:
- Reset (reset=1 at posedge): ext_cnt=0, cnt_q=0, prim=0, FIFO empty (rd/wr pointers=0), cap_valid=0, cap_data=0, fifo_full=0, drop_count=0, ovf_seen=0, ovf_rise=0. Reset asserted mid-operation discards all FIFO contents at the next edge.
- Sampling: cnt_q <= cnt_in every cycle. prim <= 1 on the first non-reset cycle. While prim=0, no wrap detection occurs.
- Wrap detect: wrap = prim && (cnt_q == all-ones) && (cnt_in == 0).
  - On wrap, ext_cnt <= ext_cnt+1, modulo 2^EXT_W; rollover is silent.
  - Any other transition, including a jump caused by upstream reset, is not a wrap.
- Capture value: {ext_nxt, cnt_in}, where ext_nxt = ext_cnt + wrap. A capture in the same cycle as a wrap records the already-incremented extension, so timestamps stay monotonic.
- Push = capture_req. Pop = cap_valid && cap_ready.
- Empty: push writes; cap_valid rises the next cycle (1-cycle latency); no same-cycle bypass.
- Full:
  - Push with pop in the same cycle: both happen; occupancy unchanged; entry accepted.
  - Push without pop: entry dropped; drop_count += 1, saturating at 2^DROP_W-1.
- Pop order is strictly FIFO. cap_data is the registered/array head and is stable while cap_valid && !cap_ready.
- fifo_full and cap_valid derive from registered occupancy (count of 0..DEPTH) and are glitch-free.
- ovf_seen <= ovf_in. ovf_rise <= ovf_in && !ovf_seen.
- Simultaneous reset and any event: reset wins.

Decomposition:
- Package counter_capture_pkg:
  - CNT_W_DEF, EXT_W_DEF, DEPTH_DEF, DROP_W_DEF constants.
  - Typedef for the capture entry struct {ext, cnt}.
- Sub-module cap_sync_fifo (WIDTH, DEPTH): synchronous FIFO.
  - Interface: push/pop, full/empty, data.
  - Pointers are log2(DEPTH)+1 bits wide.
  - Same-cycle push+pop allowed when full.
- The top level holds the sampling, wrap detection, extension counter, drop counter and overflow edge logic.

Test Plan:
- Reset then count 0..15,0 with enable -> ext_cnt 0 until cnt_in goes F->0, then 1. Capture at cnt_in=3 afterwards -> cap_data=0x0013 one cycle later.
- Capture in the exact cycle cnt_in goes F->0 -> entry {ext=1, cnt=0}, i.e. 0x0010, not 0x0000.
- cap_ready=0, 6 captures at distinct values -> first 4 stored, fifo_full=1, drop_count=2. Then drain with cap_ready=1 -> same 4 values in order, fifo_full drops after the first pop.
- FIFO full, capture_req and cap_ready both 1 for 3 cycles -> drop_count unchanged, occupancy stays 4, output order preserved.
- Force ext_cnt to 0xFFF via 4095 wraps, then one more wrap -> ext=0x000 with no flag. Separately, 300 overflowing captures -> drop_count saturates at 255.
- ovf_in rises at cycle 20 -> ovf_seen=1 from cycle 21, ovf_rise=1 for cycle 21 only. Assert reset with 2 entries queued -> cap_valid=0 and drop_count=0 next cycle.
